// File: rtl/shift_arbiter.sv
// Purpose: round-robin share of one 32-bit barrel shifter (SLL/SRL/SRA) between requesters A and B.
// Latency: 1 cycle from accept to out_valid/out_data; full throughput while out_ready is high.
// Backpressure: a_ready/b_ready drop while the result register is held (out_valid & !out_ready).
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   a_*/b_*           requester valid/ready handshake with data, shift amount and op
//                     (op 00 SLL, 01 SRL, 10 SRA, 11 illegal -> data passed through, err flagged)
//   out_*             one-entry result register: valid/ready, data, source id (0=A, 1=B), err
//   cnt_a, cnt_b      accepted-request counters, wrap modulo 2^CW
module shift_arbiter #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [N-1:0]  a_data,
  input  logic [4:0]    a_shamt,
  input  logic [1:0]    a_op,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [N-1:0]  b_data,
  input  logic [4:0]    b_shamt,
  input  logic [1:0]    b_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_id,
  output logic          out_err,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q,  out_data_d;
  logic          out_id_q,    out_id_d;
  logic          out_err_q,   out_err_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;

  logic          slot_free;
  logic          grant_a, grant_b;
  logic          accept;
  logic [N-1:0]  sel_data;
  logic [4:0]    sel_shamt;
  logic [1:0]    sel_op;
  logic [N-1:0]  shift_res;

  // Readys depend only on valids and the output register state, never on operands.
  // On contention the requester that did not win last time gets the slot;
  // last_grant resets to B so that A wins the first contention.
  always_comb begin
    slot_free = !out_valid_q | out_ready;
    grant_a   = a_valid & (!b_valid | last_grant_q);
    grant_b   = b_valid & (!a_valid | !last_grant_q);
    a_ready   = slot_free & grant_a;
    b_ready   = slot_free & grant_b;
    accept    = a_ready | b_ready;
  end

  // Operand mux feeding the single shifter; grant_b alone selects B.
  always_comb begin
    sel_data  = grant_b ? b_data  : a_data;
    sel_shamt = grant_b ? b_shamt : a_shamt;
    sel_op    = grant_b ? b_op    : a_op;
    shift_res = sel_data;
    case (sel_op)
      OP_SLL:  shift_res = sel_data << sel_shamt;
      OP_SRL:  shift_res = sel_data >> sel_shamt;
      OP_SRA:  shift_res = $signed(sel_data) >>> sel_shamt;
      default: shift_res = sel_data;
    endcase
  end

  // Drain and accept in the same cycle simply reloads the register, keeping out_valid high.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    out_err_d    = out_err_q;
    last_grant_d = last_grant_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = shift_res;
      out_id_d     = grant_b;
      out_err_d    = (sel_op == OP_ILL);
      last_grant_d = grant_b;
      if (a_ready) cnt_a_d = cnt_a_q + CNT_ONE;
      if (b_ready) cnt_b_d = cnt_b_q + CNT_ONE;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
      out_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      out_err_q    <= out_err_d;
      last_grant_q <= last_grant_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose: self-checking bench for shift_arbiter against a behavioural reference model.
// Latency: checks readys before each edge and all outputs 1 time unit after it.
// Backpressure: out_ready is driven directed and randomized; stalls are checked every cycle.
module tb_shift_arbiter;
  localparam int N  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, out_ready;
  logic          a_ready, b_ready;
  logic [N-1:0]  a_data, b_data;
  logic [4:0]    a_shamt, b_shamt;
  logic [1:0]    a_op, b_op;
  logic          out_valid, out_id, out_err;
  logic [N-1:0]  out_data;
  logic [CW-1:0] cnt_a, cnt_b;

  shift_arbiter #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_shamt(a_shamt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_shamt(b_shamt), .b_op(b_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_err(out_err), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift reference by plain arithmetic: multiply/divide by 2**s, floor division for SRA.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] op);
    longint unsigned p  = 64'd1 << s;
    longint unsigned du = {32'd0, d};
    longint unsigned r;
    logic [31:0] q;
    case (op)
      2'd0: begin r = (du * p) % (64'd1 << 32); return r[31:0]; end
      2'd1: return d / p[31:0];
      2'd2: begin
        if (d[31]) begin
          // floor(v/p) for negative v equals -floor((-v-1)/p) - 1
          q = (~d) / p[31:0];
          return ~q;
        end
        return d / p[31:0];
      end
      default: return d;
    endcase
  endfunction

  // Reference model state.
  logic          m_valid, m_id, m_err, m_last;
  logic [N-1:0]  m_data;
  logic [CW-1:0] m_cnt_a, m_cnt_b;
  logic          acc_a, acc_b;

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_err = 0;
    m_last  = 1;   // A is owed the first contention
    m_cnt_a = 0; m_cnt_b = 0;
    acc_a = 0; acc_b = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, out_valid, m_valid);
    check({tag, ".out_data"},  out_data,  m_data);
    check({tag, ".out_id"},    out_id,    m_id);
    check({tag, ".out_err"},   out_err,   m_err);
    check({tag, ".cnt_a"},     cnt_a,     m_cnt_a);
    check({tag, ".cnt_b"},     cnt_b,     m_cnt_b);
  endtask

  // One clock cycle: called at negedge with inputs already driven.
  task automatic step(input string tag);
    logic room, winner_b, ea, eb;
    #1;
    room     = !m_valid || out_ready;
    winner_b = (a_valid && b_valid) ? (m_last == 1'b0) : b_valid;
    ea = room && a_valid && !winner_b;
    eb = room && b_valid && winner_b;
    check({tag, ".a_ready"}, a_ready, ea);
    check({tag, ".b_ready"}, b_ready, eb);
    @(posedge clk);
    if (ea) begin
      m_valid = 1; m_data = ref_shift(a_data, a_shamt, a_op); m_id = 0;
      m_err = (a_op == 2'd3); m_last = 0; m_cnt_a = m_cnt_a + 1'b1;
    end else if (eb) begin
      m_valid = 1; m_data = ref_shift(b_data, b_shamt, b_op); m_id = 1;
      m_err = (b_op == 2'd3); m_last = 1; m_cnt_b = m_cnt_b + 1'b1;
    end else if (out_ready) begin
      m_valid = 0;
    end
    acc_a = ea; acc_b = eb;
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    a_valid = v; a_data = d; a_shamt = s; a_op = op;
  endtask

  task automatic set_b(input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    b_valid = v; b_data = d; b_shamt = s; b_op = op;
  endtask

  // Reset asserted away from any edge, checked while held, released at a negedge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs(tag);
    repeat (2) @(posedge clk);
    #1 check_outputs({tag, ".held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [0:0] exp_id [4];
    rst = 1'b0;
    out_ready = 1'b0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs("rst0");
    @(negedge clk);
    rst = 1'b1;

    // Directed shifts from A.
    out_ready = 1'b1;
    set_a(1, 32'h8000_0000, 5'd4, 2'b10); step("sra");
    check("sra.val", out_data, 32'hF800_0000);
    set_a(1, 32'h8000_0000, 5'd4, 2'b01); step("srl");
    check("srl.val", out_data, 32'h0800_0000);
    set_a(1, 32'h0000_0001, 5'd31, 2'b00); step("sll");
    check("sll.val", out_data, 32'h8000_0000);
    check("sll.cnt_a", cnt_a, 4'd3);
    set_a(1, 32'hDEAD_BEEF, 5'd0, 2'b10); step("sra0");
    check("sra0.val", out_data, 32'hDEAD_BEEF);

    // Illegal op from B and SRA boundaries.
    set_a(0, 0, 0, 0);
    set_b(1, 32'h1234_ABCD, 5'd7, 2'b11); step("ill");
    check("ill.data", out_data, 32'h1234_ABCD);
    check("ill.err", out_err, 1'b1);
    check("ill.id", out_id, 1'b1);
    set_b(0, 0, 0, 0);
    set_a(1, 32'h7FFF_FFFF, 5'd31, 2'b10); step("sra_pos");
    check("sra_pos.val", out_data, 32'h0000_0000);
    set_a(1, 32'hFFFF_FFFF, 5'd31, 2'b10); step("sra_neg");
    check("sra_neg.val", out_data, 32'hFFFF_FFFF);

    // Backpressure: held result, A waiting, then release with no bubble.
    out_ready = 1'b0;
    set_a(1, 32'h0000_00F0, 5'd4, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stall.data", out_data, 32'hFFFF_FFFF);
    end
    out_ready = 1'b1;
    step("release");
    check("release.acc", acc_a, 1'b1);
    check("release.data", out_data, 32'h0000_000F);

    // Mid-stream reset with a result pending, then contention.
    out_ready = 1'b0;
    set_a(1, 32'h0000_0003, 5'd1, 2'b00); step("pend");
    do_reset("rst_mid");
    out_ready = 1'b1;
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_a(1, 32'h0000_0100 + i, 5'(i), 2'b00);
      set_b(1, 32'hF000_0000 + i, 5'(i), 2'b10);
      step("cont");
      check("cont.id", out_id, exp_id[i]);
    end
    check("cont.cnt_a", cnt_a, 4'd2);
    check("cont.cnt_b", cnt_b, 4'd2);

    // Counter wrap at CW = 4.
    set_b(0, 0, 0, 0);
    do_reset("rst_wrap");
    for (int i = 0; i < 17; i++) begin
      set_a(1, 32'(i), 5'(i), 2'b01);
      step("wrap");
    end
    check("wrap.cnt_a", cnt_a, 4'd1);
    check("wrap.cnt_b", cnt_b, 4'd0);

    // Randomized traffic: requesters hold until accepted or occasionally drop.
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!a_valid || acc_a || $urandom_range(0, 9) == 0)
        set_a(($urandom_range(0, 9) < 6), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      if (!b_valid || acc_b || $urandom_range(0, 9) == 0)
        set_b(($urandom_range(0, 9) < 6), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

endmodule
